// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit single-issue cpu: widths, opcodes and
// the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W   = 16;
    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_LD  = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_ST  = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_BEQ = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'hD;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        HALT_DRAIN = 2'b01,
        HALTED     = 2'b10
    } fetch_state_t;

    // Instructions are halfword aligned, so branch targets drop bit 0.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return addr & ~{{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_halt_fsm.sv
// Halt sequencing for the fetch stage: RUN -> HALT_DRAIN -> HALTED, with a
// drain counter that lets the HLT clear the downstream pipeline before hlt rises.
module fetch_halt_fsm
    import cpu_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hlt_seen,
    input  logic       stall,
    input  logic       redirect,
    output logic [1:0] state,
    output logic       hlt
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    fetch_state_t state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic         hlt_reg, hlt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            hlt_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hlt_reg   <= hlt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hlt_next   = hlt_reg;
        case (state_reg)
            RUN: begin
                if (!redirect && !stall && hlt_seen) begin
                    state_next = HALT_DRAIN;
                    cnt_next   = DRAIN_LOAD;
                end
            end
            HALT_DRAIN: begin
                // A redirect here means the HLT was fetched down a wrong path.
                if (redirect) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else if (!stall) begin
                    if (cnt_reg == 4'd0) begin
                        state_next = HALTED;
                        hlt_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 4'd1;
                    end
                end
            end
            HALTED: begin
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
    end

    assign state = state_reg;
    assign hlt   = hlt_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory request and IF/ID register.
// Define FETCH_PERF_EN to build the flushed-instruction counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET     = 16'h0000,
    parameter logic [15:0] PC_INC       = 16'd2,
    parameter logic [3:0]  HLT_OPCODE   = OP_HLT,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_next,
    output logic [15:0] pc,
    output logic        hlt,
    output logic [15:0] perf_flush_cnt
);

    logic [15:0] pc_reg, pc_next;
    logic        valid_reg, valid_next;
    logic [15:0] instr_reg, instr_next;
    logic [15:0] ipc_reg, ipc_next;
    logic [15:0] ipcn_reg, ipcn_next;
    logic [1:0]  state;
    logic        in_run, halted, hlt_seen;
    logic [15:0] pc_inc;

    assign in_run   = (state == RUN);
    assign halted   = (state == HALTED);
    assign hlt_seen = in_run && (imem_data[15:12] == HLT_OPCODE);
    assign pc_inc   = pc_reg + PC_INC;

    fetch_halt_fsm #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_halt_fsm (
        .clk     (clk),
        .rst     (rst),
        .hlt_seen(hlt_seen),
        .stall   (stall),
        .redirect(redirect),
        .state   (state),
        .hlt     (hlt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= PC_RESET;
            valid_reg <= 1'b0;
            instr_reg <= '0;
            ipc_reg   <= '0;
            ipcn_reg  <= '0;
        end else begin
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            ipc_reg   <= ipc_next;
            ipcn_reg  <= ipcn_next;
        end
    end

    // Priority: redirect over stall over fetch; HALTED freezes everything.
    always_comb begin
        pc_next    = pc_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        ipc_next   = ipc_reg;
        ipcn_next  = ipcn_reg;
        if (!halted) begin
            if (redirect) begin
                pc_next    = align_pc(redirect_pc);
                valid_next = 1'b0;
            end else if (!stall) begin
                if (in_run) begin
                    instr_next = imem_data;
                    ipc_next   = pc_reg;
                    ipcn_next  = pc_inc;
                    valid_next = 1'b1;
                    // PC parks on the HLT so a halted core reports where it stopped.
                    if (!hlt_seen) begin
                        pc_next = pc_inc;
                    end
                end else begin
                    valid_next = 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_reg;
    logic        flush_live;

    assign flush_live = redirect && valid_reg && !halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (flush_live && (perf_reg != 16'hFFFF)) begin
            perf_reg <= perf_reg + 16'd1;
        end
    end

    assign perf_flush_cnt = perf_reg;
`else
    assign perf_flush_cnt = 16'h0000;
`endif

    assign imem_addr  = pc_reg;
    assign imem_rd    = in_run;
    assign pc         = pc_reg;
    assign if_valid   = valid_reg;
    assign if_instr   = instr_reg;
    assign if_pc      = ipc_reg;
    assign if_pc_next = ipcn_reg;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage feeding instruction memory and the decode stage of the 16-bit single-issue cpu. It holds the PC, drives the instruction-memory address and read enable, and captures the returned word into the IF/ID pipeline register. It accepts stall and branch-redirect from downstream. It detects the HLT opcode, drains the pipeline, then asserts the halt flag.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per fetched instruction (16-bit instructions)
HLT_OPCODE, 4'hF, opcode (instr[15:12]) that starts halt
DRAIN_CYCLES, 4, cycles between HLT fetch and hlt assertion (downstream pipeline depth); legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  decode not ready; hold PC and IF/ID register
redirect  in  1  taken branch or jump resolved downstream
redirect_pc  in  16  target PC for redirect
imem_addr  out  16  instruction-memory address (= current PC)
imem_rd  out  1  instruction-memory read enable
imem_data  in  16  instruction word; combinational read, valid in the same cycle as imem_addr
if_valid  out  1  IF/ID register holds a live instruction
if_instr  out  16  IF/ID instruction
if_pc  out  16  PC of if_instr
if_pc_next  out  16  if_pc + PC_INC, used by the downstream branch adder
pc  out  16  current PC, observable at top level
hlt  out  1  processor halted
perf_flush_cnt  out  16  flushed-instruction count (see Optional Feature)

Behaviour:
- Reset (async, asserts immediately):
  - PC=PC_RESET; if_valid=0; if_instr=0; if_pc=0; if_pc_next=0; hlt=0; state=RUN; drain counter=0.
- imem_addr=PC always. imem_rd=1 only in RUN.
- Priority each cycle: redirect > stall > normal fetch.
- RUN, normal fetch (no stall, no redirect):
  - IF/ID <= {imem_data, PC, PC+PC_INC}; if_valid<=1; PC<=PC+PC_INC.
- PC arithmetic is 16-bit modulo: 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Stall, no redirect:
  - PC and IF/ID unchanged; if_valid held.
  - Drain counter also frozen.
- Redirect (any state except HALTED, regardless of stall):
  - PC <= {redirect_pc[15:1],1'b0}; bit 0 is forced to 0.
  - if_valid<=0; the flush is a one-cycle bubble.
  - A redirect in HALT_DRAIN returns to RUN with counter cleared, because the HLT was on a wrong path.
- HLT detect (RUN, normal fetch, imem_data[15:12]==HLT_OPCODE):
  - HLT is latched into IF/ID like any instruction.
  - PC is NOT incremented.
  - state<=HALT_DRAIN; counter<=DRAIN_CYCLES-1.
- HALT_DRAIN:
  - imem_rd=0; no new fetch.
  - On a non-stalled cycle, if_valid<=0; the HLT passes downstream once.
  - Counter decrements per non-stalled cycle. At 0 with no redirect, state<=HALTED.
- HALTED:
  - hlt=1 (registered, asserted the cycle state becomes HALTED).
  - Absorbing: redirect and stall ignored; only rst exits.
  - PC holds the HLT address.
- Reset mid-operation: all of the above abandoned; reset values apply asynchronously, including during HALT_DRAIN.
- States: RUN -> HALT_DRAIN on HLT; HALT_DRAIN -> RUN on redirect; HALT_DRAIN -> HALTED on counter 0; HALTED -> RUN only via rst.

Optional Feature:
FETCH_PERF_EN
- Defined: perf_flush_cnt increments by 1 on every redirect cycle in which if_valid was 1 (a live instruction discarded).
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Frozen in HALTED.
- Undefined: perf_flush_cnt tied to 16'h0000; no counter flops synthesized.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W=16, INSTR_W=16, OPCODE_W=4.
  - Opcode constants, including OP_HLT=4'hF.
  - Fetch state encoding: RUN=2'b00, HALT_DRAIN=2'b01, HALTED=2'b10.
- One natural sub-module: fetch_halt_fsm. It holds the state register and drain counter. Inputs: hlt_seen, stall, redirect. Outputs: state, hlt.
- PC, next-PC mux and IF/ID register stay in fetch_stage.

Test Plan:
- Reset/fetch: rst pulse, imem returns 16'h1234 at 0 and 16'h5678 at 2 -> pc 0,2,4 on successive edges; if_instr=16'h1234 with if_pc=0 and if_pc_next=2, then 16'h5678 with if_pc=2.
- Stall: assert stall 3 cycles at PC=16'h0010 -> pc and if_instr constant for 3 cycles; fetch resumes at 16'h0010.
- Redirect priority: stall=1 and redirect=1 with redirect_pc=16'h0041 -> pc=16'h0040 next edge; if_valid=0 for one cycle; with FETCH_PERF_EN, perf_flush_cnt=1.
- Wrap: PC=16'hFFFE, normal fetch -> pc=16'h0000, if_pc_next=16'h0000.
- Halt: 16'hF000 fetched at 16'h0020, DRAIN_CYCLES=4, no stall -> if_valid high 1 cycle; imem_rd=0; hlt rises exactly 4 cycles after the HLT fetch edge; pc stays 16'h0020; a later redirect is ignored.
- Wrong-path halt: HLT fetched, redirect to 16'h0100 during HALT_DRAIN -> state RUN, hlt never asserts, pc=16'h0100.
